// File: rtl/sram_master.sv
// Request-driven master for a synchronous SRAM with one-cycle registered read data.
// Writes are single words; reads are pipelined bursts of up to 16 words with a two-edge return latency.
module sram_master #(
   parameter int DEPTH_LOG2 = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   input  logic [3:0]  req_len,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_last,
   output logic        rsp_err,
   output logic        sram_we_n,
   output logic [15:0] sram_addr,
   output logic [15:0] sram_wdata,
   input  logic [15:0] sram_rdata
);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      DRAIN,
      ERR
   } state_t;

   state_t                state;
   logic [3:0]            len_q;
   logic [4:0]            issue_cnt;
   logic [4:0]            ret_cnt;
   logic                  issue_v;
   logic                  data_v;
   logic                  in_range;
   logic [DEPTH_LOG2-1:0] addr_next;

   assign req_ready = (state == IDLE);
   assign in_range  = (req_addr[15:DEPTH_LOG2] == '0);
   assign addr_next = sram_addr[DEPTH_LOG2-1:0] + DEPTH_LOG2'(1);

   // issue_v marks a read address on the bus; data_v follows one edge later when the SRAM data is valid
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sram_we_n  <= 1'b1;
         sram_addr  <= '0;
         sram_wdata <= '0;
         rsp_valid  <= 1'b0;
         rsp_last   <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_rdata  <= '0;
         len_q      <= '0;
         issue_cnt  <= '0;
         ret_cnt    <= '0;
         issue_v    <= 1'b0;
         data_v     <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_last  <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         data_v    <= issue_v;

         if (data_v) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= sram_rdata;
            rsp_last  <= (ret_cnt == {1'b0, len_q});
            ret_cnt   <= ret_cnt + 5'd1;
         end

         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (!in_range) begin
                     state <= ERR;
                  end else if (req_we) begin
                     sram_we_n  <= 1'b0;
                     sram_addr  <= req_addr;
                     sram_wdata <= req_wdata;
                     state      <= WRITE;
                  end else begin
                     sram_addr <= req_addr;
                     len_q     <= req_len;
                     issue_cnt <= 5'd1;
                     ret_cnt   <= 5'd0;
                     issue_v   <= 1'b1;
                     state     <= (req_len == 4'd0) ? DRAIN : READ;
                  end
               end
            end
            WRITE: begin
               sram_we_n <= 1'b1;
               rsp_valid <= 1'b1;
               rsp_last  <= 1'b1;
               state     <= IDLE;
            end
            ERR: begin
               rsp_valid <= 1'b1;
               rsp_last  <= 1'b1;
               rsp_err   <= 1'b1;
               state     <= IDLE;
            end
            READ: begin
               sram_addr <= {{(16 - DEPTH_LOG2){1'b0}}, addr_next};
               issue_cnt <= issue_cnt + 5'd1;
               if (issue_cnt == {1'b0, len_q}) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               issue_v <= 1'b0;
               if (data_v && (ret_cnt == {1'b0, len_q})) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_master.sv
// Bench for sram_master: directed vector table, multi-cycle corner sequences and randomized
// traffic, all scored against a word-level memory model and a queue of expected response beats.
module tb_sram_master;

   localparam int DEPTH_LOG2 = 5;
   localparam int WORDS      = 1 << DEPTH_LOG2;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic [3:0]  req_len;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_last;
   logic        rsp_err;
   logic        sram_we_n;
   logic [15:0] sram_addr;
   logic [15:0] sram_wdata;
   logic [15:0] sram_rdata;

   logic [15:0] mem [WORDS];
   logic        preload_en;

   typedef struct {
      logic [15:0] data;
      logic        last;
      logic        err;
   } beat_t;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [3:0]  len;
      logic        exp_err;
      int          exp_beats;
      logic [15:0] exp_first;
      logic [15:0] exp_final;
      int          exp_lat;
      int          exp_ready;
   } vec_t;

   typedef struct {
      int          beats;
      int          first_idx;
      logic [15:0] first_data;
      logic [15:0] final_data;
      logic        err_seen;
      int          last_cnt;
      int          last_beat;
      logic        gap;
      int          ready_idx;
   } obs_t;

   beat_t       sb_q[$];
   logic [15:0] ref_mem [WORDS];
   logic        we_due;
   logic [15:0] we_addr;
   logic [15:0] we_data;
   int          checks;
   int          errors;
   int          accept_count;

   sram_master #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_len    (req_len),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_last   (rsp_last),
      .rsp_err    (rsp_err),
      .sram_we_n  (sram_we_n),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (preload_en) begin
         for (int i = 0; i < WORDS; i++) mem[i] <= 16'hA000 + 16'(i);
      end else if (sram_we_n == 1'b0) begin
         mem[sram_addr[DEPTH_LOG2-1:0]] <= sram_wdata;
      end
      sram_rdata <= mem[sram_addr[DEPTH_LOG2-1:0]];
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Every negedge passes through here: score outputs, then predict the acceptance at the coming edge.
   task automatic tick();
      beat_t e;
      @(negedge clk);
      if (we_due || sram_we_n !== 1'b1) begin
         checkOutput("sram_we_n", 16'(sram_we_n), we_due ? 16'd0 : 16'd1);
         if (we_due) begin
            checkOutput("sram_addr on write", sram_addr, we_addr);
            checkOutput("sram_wdata on write", sram_wdata, we_data);
         end
      end
      we_due = 1'b0;
      if (rsp_valid !== 1'b0) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected rsp_valid: actual %b, expected 0 (data 0x%0h)", rsp_valid, rsp_rdata);
         end else begin
            e = sb_q.pop_front();
            checkOutput("rsp_rdata", rsp_rdata, e.data);
            checkOutput("rsp_last", 16'(rsp_last), 16'(e.last));
            checkOutput("rsp_err", 16'(rsp_err), 16'(e.err));
         end
      end
      if (preload_en) begin
         for (int i = 0; i < WORDS; i++) ref_mem[i] = 16'hA000 + 16'(i);
      end
      if (rst) begin
         sb_q.delete();
      end else if (req_valid === 1'b1 && req_ready === 1'b1) begin
         accept_count++;
         if (int'(req_addr) >= WORDS) begin
            e = '{16'h0000, 1'b1, 1'b1};
            sb_q.push_back(e);
         end else if (req_we) begin
            ref_mem[int'(req_addr)] = req_wdata;
            e = '{16'h0000, 1'b1, 1'b0};
            sb_q.push_back(e);
            we_due  = 1'b1;
            we_addr = req_addr;
            we_data = req_wdata;
         end else begin
            for (int k = 0; k <= int'(req_len); k++) begin
               e = '{ref_mem[(int'(req_addr) + k) % WORDS], (k == int'(req_len)), 1'b0};
               sb_q.push_back(e);
            end
         end
      end
   endtask

   task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                                input logic [3:0] len);
      logic ok;
      @(posedge clk);
      #1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_len   = len;
      req_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (req_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("request accepted", 16'(ok), 16'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic collectResponse(input int window, output obs_t o);
      int prev;
      o = '{0, 0, 16'h0, 16'h0, 1'b0, 0, 0, 1'b0, 0};
      prev = 0;
      for (int idx = 1; idx <= window; idx++) begin
         tick();
         if (rsp_valid === 1'b1) begin
            o.beats++;
            if (o.beats == 1) begin
               o.first_idx  = idx;
               o.first_data = rsp_rdata;
            end else if (idx != prev + 1) begin
               o.gap = 1'b1;
            end
            prev = idx;
            o.final_data = rsp_rdata;
            if (rsp_err === 1'b1) o.err_seen = 1'b1;
            if (rsp_last === 1'b1) begin
               o.last_cnt++;
               o.last_beat = o.beats;
            end
         end
         if (o.ready_idx == 0 && req_ready === 1'b1) o.ready_idx = idx;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         tick();
         if (sb_q.size() == 0 && req_ready === 1'b1) break;
      end
      checkOutput("scoreboard drained", 16'(sb_q.size()), 16'd0);
   endtask

   vec_t vecs[11];
   obs_t obs;
   int   acc_before;
   int   stray;
   logic ok;

   initial begin
      checks       = 0;
      errors       = 0;
      accept_count = 0;
      we_due       = 1'b0;
      we_addr      = '0;
      we_data      = '0;
      preload_en   = 1'b1;
      rst          = 1'b1;
      req_valid    = 1'b1;
      req_we       = 1'b1;
      req_addr     = 16'd9;
      req_wdata    = 16'hBEEF;
      req_len      = 4'd0;

      vecs[0]  = '{1'b0, 16'h0000, 16'h0000, 4'd15, 1'b0, 16, 16'hA000, 16'hA00F, 3, 18};
      vecs[1]  = '{1'b1, 16'h0005, 16'h1234, 4'd0,  1'b0, 1,  16'h0000, 16'h0000, 2, 2};
      vecs[2]  = '{1'b0, 16'h0005, 16'h0000, 4'd0,  1'b0, 1,  16'h1234, 16'h1234, 3, 3};
      vecs[3]  = '{1'b0, 16'h001E, 16'h0000, 4'd3,  1'b0, 4,  16'hA01E, 16'hA001, 3, 6};
      vecs[4]  = '{1'b1, 16'h0020, 16'hDEAD, 4'd0,  1'b1, 1,  16'h0000, 16'h0000, 2, 2};
      vecs[5]  = '{1'b0, 16'h0000, 16'h0000, 4'd0,  1'b0, 1,  16'hA000, 16'hA000, 3, 3};
      vecs[6]  = '{1'b0, 16'h8001, 16'h0000, 4'd4,  1'b1, 1,  16'h0000, 16'h0000, 2, 2};
      vecs[7]  = '{1'b1, 16'h001F, 16'h5555, 4'd0,  1'b0, 1,  16'h0000, 16'h0000, 2, 2};
      vecs[8]  = '{1'b0, 16'h001F, 16'h0000, 4'd1,  1'b0, 2,  16'h5555, 16'hA000, 3, 4};
      vecs[9]  = '{1'b1, 16'h0007, 16'h0F0F, 4'd9,  1'b0, 1,  16'h0000, 16'h0000, 2, 2};
      vecs[10] = '{1'b0, 16'h0007, 16'h0000, 4'd0,  1'b0, 1,  16'h0F0F, 16'h0F0F, 3, 3};

      repeat (3) tick();
      checkOutput("reset req_ready", 16'(req_ready), 16'd1);
      checkOutput("reset sram_we_n", 16'(sram_we_n), 16'd1);
      checkOutput("reset sram_addr", sram_addr, 16'h0000);
      checkOutput("reset sram_wdata", sram_wdata, 16'h0000);
      checkOutput("reset rsp_valid", 16'(rsp_valid), 16'd0);
      checkOutput("reset rsp_last", 16'(rsp_last), 16'd0);
      checkOutput("reset rsp_err", 16'(rsp_err), 16'd0);
      checkOutput("reset rsp_rdata", rsp_rdata, 16'h0000);
      @(posedge clk);
      #1;
      rst        = 1'b0;
      req_valid  = 1'b0;
      preload_en = 1'b0;
      repeat (3) tick();
      checkOutput("ready after reset", 16'(req_ready), 16'd1);
      checkOutput("no write during reset", mem[9], 16'hA009);

      $display("[TB] directed vector table");
      for (int v = 0; v < 11; v++) begin
         applyStimulus(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].len);
         collectResponse(22, obs);
         checkOutput($sformatf("vec%0d beats", v), 16'(obs.beats), 16'(vecs[v].exp_beats));
         checkOutput($sformatf("vec%0d err", v), 16'(obs.err_seen), 16'(vecs[v].exp_err));
         checkOutput($sformatf("vec%0d first data", v), obs.first_data, vecs[v].exp_first);
         checkOutput($sformatf("vec%0d final data", v), obs.final_data, vecs[v].exp_final);
         checkOutput($sformatf("vec%0d latency", v), 16'(obs.first_idx), 16'(vecs[v].exp_lat));
         checkOutput($sformatf("vec%0d ready return", v), 16'(obs.ready_idx), 16'(vecs[v].exp_ready));
         checkOutput($sformatf("vec%0d last count", v), 16'(obs.last_cnt), 16'd1);
         checkOutput($sformatf("vec%0d last position", v), 16'(obs.last_beat), 16'(vecs[v].exp_beats));
         checkOutput($sformatf("vec%0d beat gap", v), 16'(obs.gap), 16'd0);
      end
      checkOutput("out-of-range write left mem[0]", mem[0], 16'hA000);

      $display("[TB] reset during beat 2 of an 8-word read");
      applyStimulus(1'b0, 16'h0000, 16'h0000, 4'd7);
      repeat (4) tick();
      @(posedge clk);
      #1;
      rst = 1'b1;
      tick();
      checkOutput("beat 2 visible at reset", rsp_rdata, 16'hA002);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      checkOutput("post-reset sram_addr", sram_addr, 16'h0000);
      checkOutput("post-reset req_ready", 16'(req_ready), 16'd1);
      stray = 0;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) tick();
         if (rsp_valid !== 1'b0) stray++;
         if (sram_addr !== 16'h0000) stray++;
      end
      checkOutput("activity after reset", 16'(stray), 16'd0);
      applyStimulus(1'b0, 16'h0003, 16'h0000, 4'd0);
      collectResponse(6, obs);
      checkOutput("post-reset read beats", 16'(obs.beats), 16'd1);
      checkOutput("post-reset read data", obs.first_data, 16'hA003);

      $display("[TB] req_valid held high across alternating requests");
      acc_before = accept_count;
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 16'd12;
      req_wdata = 16'hC000;
      req_len   = 4'd1;
      for (int n = 0; n < 6; n++) begin
         ok = 1'b0;
         for (int i = 0; i < 60; i++) begin
            tick();
            if (req_ready === 1'b1) begin
               ok = 1'b1;
               break;
            end
         end
         checkOutput("held request accepted", 16'(ok), 16'd1);
         @(posedge clk);
         #1;
         if (n < 5) begin
            req_we    = ((n + 1) % 2 == 0);
            req_addr  = 16'(12 + (n + 1) / 2);
            req_wdata = 16'hC000 + 16'(n + 1);
            req_len   = 4'd1;
         end else begin
            req_valid = 1'b0;
         end
         tick();
         checkOutput("busy after accept", 16'(req_ready), 16'd0);
      end
      drain();
      checkOutput("held-valid accept count", 16'(accept_count - acc_before), 16'd6);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 60; n++) begin
         logic        r_we;
         logic [15:0] r_addr;
         r_we = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) r_addr = 16'($urandom_range(WORDS, 16'hFFFF));
         else r_addr = 16'($urandom_range(0, WORDS - 1));
         applyStimulus(r_we, r_addr, 16'($urandom), 4'($urandom_range(0, 15)));
         repeat (1 + $urandom_range(0, 3)) tick();
      end
      drain();
      for (int i = 0; i < WORDS; i++) begin
         checkOutput($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
